// File: rtl/config_chain_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// config_chain_sequencer_if : host word interface (valid/ready, status, readback)
// Rev 1.0
// ----------------------------------------------------------------------------
interface config_chain_sequencer_if #(
   parameter int CHAIN_LEN = 4
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [CHAIN_LEN-1:0] cfg_data;
   logic                 busy;
   logic                 done;
   logic [CHAIN_LEN-1:0] rd_data;

   modport master (
      output cfg_valid, cfg_data,
      input  cfg_ready, busy, done, rd_data
   );

   modport slave (
      input  cfg_valid, cfg_data,
      output cfg_ready, busy, done, rd_data
   );
endinterface
`default_nettype wire

// File: rtl/config_chain_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// config_chain_sequencer : shifts one word into a tile latch chain with
// non-overlapping CLK/MODE strobes and captures CONFout after each pulse.
// Rev 1.0
// ----------------------------------------------------------------------------
module config_chain_sequencer #(
   parameter int CHAIN_LEN = 4,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 1,
   parameter int HOLD_CYC  = 1
) (
   input  wire logic               CLK,
   input  wire logic               resetn,
   config_chain_sequencer_if.slave host,
   output logic                    CONF_D,
   output logic                    CONF_CLK,
   output logic                    CONF_MODE,
   input  wire logic               CONF_Q
);

   localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int K_W     = $clog2(CHAIN_LEN);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [K_W-1:0]   K_LAST     = K_W'(CHAIN_LEN - 1);

   if ((CHAIN_LEN < 2) || ((CHAIN_LEN % 2) != 0)) begin : g_bad_chain_len
      $error("CHAIN_LEN must be even and at least 2");
   end
   if ((SETUP_CYC < 1) || (PULSE_CYC < 1) || (HOLD_CYC < 1)) begin : g_bad_timing
      $error("SETUP_CYC, PULSE_CYC and HOLD_CYC must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_PULSE = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [K_W-1:0]       r_k;
   logic [CHAIN_LEN-1:0] r_shift;
   logic [CHAIN_LEN-1:0] r_rd;
   logic                 r_ready;
   logic                 r_busy;
   logic                 r_done;

   assign host.cfg_ready = r_ready;
   assign host.busy      = r_busy;
   assign host.done      = r_done;
   assign host.rd_data   = r_rd;

   // r_shift holds the bits still to be sent; the bit currently on CONF_D is already out of it.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_k       <= '0;
         r_shift   <= '0;
         r_rd      <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         CONF_D    <= 1'b0;
         CONF_CLK  <= 1'b0;
         CONF_MODE <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_ready && host.cfg_valid) begin
                  r_state <= S_SETUP;
                  r_shift <= {host.cfg_data[CHAIN_LEN-2:0], 1'b0};
                  CONF_D  <= host.cfg_data[CHAIN_LEN-1];
                  r_rd    <= '0;
                  r_k     <= '0;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            S_SETUP: begin
               if (r_cnt == SETUP_LAST) begin
                  r_state   <= S_PULSE;
                  r_cnt     <= '0;
                  CONF_CLK  <= ~r_k[0];
                  CONF_MODE <= r_k[0];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_PULSE: begin
               if (r_cnt == PULSE_LAST) begin
                  r_state   <= S_HOLD;
                  r_cnt     <= '0;
                  CONF_CLK  <= 1'b0;
                  CONF_MODE <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (r_cnt == HOLD_LAST) begin
                  r_cnt   <= '0;
                  r_rd    <= {r_rd[CHAIN_LEN-2:0], CONF_Q};
                  r_shift <= {r_shift[CHAIN_LEN-2:0], 1'b0};
                  if (r_k == K_LAST) begin
                     r_state <= S_DONE;
                     r_k     <= '0;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     CONF_D  <= 1'b0;
                  end else begin
                     r_state <= S_SETUP;
                     r_k     <= r_k + 1'b1;
                     CONF_D  <= r_shift[CHAIN_LEN-1];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_config_chain_sequencer.sv
`default_nettype none
// tb_config_chain_sequencer : scoreboard bench driving two sequencer instances
// (default timing and a stretched 2-latch configuration).
module tb_config_chain_sequencer;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   config_chain_sequencer_if #(.CHAIN_LEN(4)) ifa ();
   config_chain_sequencer_if #(.CHAIN_LEN(2)) ifb ();

   logic       d_a, clk_a, mode_a;
   logic       d_b, clk_b, mode_b;
   logic       sel   = 1'b0;
   logic       valid = 1'b0;
   logic       q     = 1'b0;
   logic [3:0] data  = 4'h0;

   assign ifa.cfg_valid = valid & ~sel;
   assign ifa.cfg_data  = data;
   assign ifb.cfg_valid = valid & sel;
   assign ifb.cfg_data  = data[1:0];

   config_chain_sequencer #(
      .CHAIN_LEN(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
   ) dut_a (
      .CLK(clk), .resetn(resetn), .host(ifa),
      .CONF_D(d_a), .CONF_CLK(clk_a), .CONF_MODE(mode_a), .CONF_Q(q)
   );

   config_chain_sequencer #(
      .CHAIN_LEN(2), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)
   ) dut_b (
      .CLK(clk), .resetn(resetn), .host(ifb),
      .CONF_D(d_b), .CONF_CLK(clk_b), .CONF_MODE(mode_b), .CONF_Q(q)
   );

   wire       o_ready = sel ? ifb.cfg_ready : ifa.cfg_ready;
   wire       o_busy  = sel ? ifb.busy      : ifa.busy;
   wire       o_done  = sel ? ifb.done      : ifa.done;
   wire [3:0] o_rd    = sel ? {2'b00, ifb.rd_data} : ifa.rd_data;
   wire       o_d     = sel ? d_b    : d_a;
   wire       o_clk   = sel ? clk_b  : clk_a;
   wire       o_mode  = sel ? mode_b : mode_a;

   int checks = 0;
   int errors = 0;
   logic [3:0] sb_q[$];
   logic [3:0] last_rd = 4'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobe monitors: no overlap, and CONF_D frozen across every strobe high/low transition.
   logic prev_s_a = 1'b0, prev_d_a = 1'b0, prev_s_b = 1'b0, prev_d_b = 1'b0;
   always @(negedge clk) begin
      if (!resetn) begin
         prev_s_a = 1'b0;
         prev_s_b = 1'b0;
      end else begin
         check("overlap_a", 32'(clk_a & mode_a), 0);
         check("overlap_b", 32'(clk_b & mode_b), 0);
         if ((clk_a | mode_a) || prev_s_a) check("d_stable_a", 32'(d_a), 32'(prev_d_a));
         if ((clk_b | mode_b) || prev_s_b) check("d_stable_b", 32'(d_b), 32'(prev_d_b));
         prev_s_a = clk_a | mode_a;
         prev_d_a = d_a;
         prev_s_b = clk_b | mode_b;
         prev_d_b = d_b;
      end
   end

   // Starts in a cycle with cfg_ready=1 and ends in the cycle after done (cfg_ready back to 1).
   task automatic run_seq(input int L, input int S, input int P, input int H,
                          input logic [3:0] word, input logic [3:0] qbits, input bit hold_valid);
      int         w;
      int         tot;
      int         k;
      int         off;
      bit         pulse;
      logic [3:0] exp;
      w   = S + P + H;
      tot = L * w;
      check("ready_pre", 32'(o_ready), 1);
      data  = word;
      valid = 1'b1;
      sb_q.push_back(qbits);
      tick();
      if (!hold_valid) valid = 1'b0;
      for (int n = 1; n <= tot; n++) begin
         k     = (n - 1) / w;
         off   = (n - 1) % w;
         pulse = (off >= S) && (off < S + P);
         q     = (off == w - 1) ? qbits[L-1-k] : ~qbits[L-1-k];
         if (hold_valid && n == 5) data = ~word;
         check("conf_d", 32'(o_d), 32'(word[L-1-k]));
         check("conf_clk", 32'(o_clk), 32'(pulse && (k % 2 == 0)));
         check("conf_mode", 32'(o_mode), 32'(pulse && (k % 2 == 1)));
         check("busy", 32'(o_busy), 1);
         check("ready_busy", 32'(o_ready), 0);
         check("done_early", 32'(o_done), 0);
         if (n == 1) check("rd_clear", 32'(o_rd), 0);
         tick();
      end
      q   = 1'b0;
      exp = sb_q.pop_front();
      check("done", 32'(o_done), 1);
      check("busy_done", 32'(o_busy), 0);
      check("ready_done", 32'(o_ready), 0);
      check("d_done", 32'(o_d), 0);
      check("strobe_done", 32'({o_clk, o_mode}), 0);
      check("rd_data", 32'(o_rd), 32'(exp));
      last_rd = exp;
      tick();
      check("ready_after", 32'(o_ready), 1);
      check("done_once", 32'(o_done), 0);
      check("rd_held", 32'(o_rd), 32'(last_rd));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      check("rst_ready_a", 32'(ifa.cfg_ready), 0);
      check("rst_busy_a", 32'(ifa.busy), 0);
      check("rst_done_a", 32'(ifa.done), 0);
      check("rst_rd_a", 32'(ifa.rd_data), 0);
      check("rst_conf_a", 32'({d_a, clk_a, mode_a}), 0);
      check("rst_ready_b", 32'(ifb.cfg_ready), 0);
      check("rst_conf_b", 32'({d_b, clk_b, mode_b}), 0);
      resetn = 1'b1;
      check("rel_ready", 32'(ifa.cfg_ready), 0);
      tick();
      check("idle_ready_a", 32'(ifa.cfg_ready), 1);
      check("idle_ready_b", 32'(ifb.cfg_ready), 1);

      // Default timing: 4'b1011 with CONFout answers 1,1,0,1.
      run_seq(4, 1, 1, 1, 4'b1011, 4'b1101, 1'b0);
      repeat (2) begin
         tick();
         check("rd_idle_hold", 32'(o_rd), 32'(last_rd));
         check("ready_idle", 32'(o_ready), 1);
      end
      run_seq(4, 1, 1, 1, 4'b0110, 4'b0011, 1'b0);

      // cfg_valid held high throughout; a mid-sequence data change must be ignored.
      run_seq(4, 1, 1, 1, 4'b1001, 4'b1010, 1'b1);
      run_seq(4, 1, 1, 1, 4'b0100, 4'b0111, 1'b0);

      // Stretched timing on the 2-latch instance.
      sel = 1'b1;
      #1;
      run_seq(2, 2, 3, 2, 4'b0010, 4'b0001, 1'b0);
      run_seq(2, 2, 3, 2, 4'b0001, 4'b0010, 1'b0);
      run_seq(2, 2, 3, 2, 4'b0011, 4'b0011, 1'b0);
      sel = 1'b0;
      #1;

      // Reset dropped mid-cycle 8 while CONF_CLK is high.
      data  = 4'b1111;
      valid = 1'b1;
      tick();
      valid = 1'b0;
      repeat (7) tick();
      check("mid_clk_hi", 32'(clk_a), 1);
      #3;
      resetn = 1'b0;
      #1;
      check("rst_async_clk", 32'(clk_a), 0);
      check("rst_async_busy", 32'(ifa.busy), 0);
      check("rst_async_d", 32'(d_a), 0);
      check("rst_async_rd", 32'(ifa.rd_data), 0);
      tick();
      check("rst_no_done", 32'(ifa.done), 0);
      #3;
      resetn = 1'b1;
      tick();
      check("rel2_ready", 32'(ifa.cfg_ready), 1);
      check("rel2_done", 32'(ifa.done), 0);
      run_seq(4, 1, 1, 1, 4'b1100, 4'b0101, 1'b0);

      // Random words and gaps on the default instance.
      for (int i = 0; i < 1000; i++) begin
         logic [3:0] w_rand;
         logic [3:0] q_rand;
         int         gap;
         w_rand = 4'($urandom_range(0, 15));
         q_rand = 4'($urandom_range(0, 15));
         gap    = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            check("gap_rd", 32'(o_rd), 32'(last_rd));
            check("gap_ready", 32'(o_ready), 1);
         end
         run_seq(4, 1, 1, 1, w_rand, q_rand, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/config_chain_sequencer.md
Name: config_chain_sequencer

Overview:
- Loads one configuration word into a tile's serial latch chain (CONFin → CONFout) by driving the data line and the two alternating latch strobes, CLK-phase and MODE-phase.
- The strobes are generated as non-overlapping pulses with programmable setup, width and hold.
- CONFout is captured after every pulse so the host can read back the bits shifted out of the chain.
- The block sits between the fabric configuration host (valid/ready word interface) and the per-tile chain ports.

Parameters:
- CHAIN_LEN, 4, number of latches in the chain and number of pulses per word; must be even and ≥2.
- SETUP_CYC, 1, cycles CONF_D is stable with both strobes low before each pulse; ≥1.
- PULSE_CYC, 1, cycles the active strobe is held high; ≥1.
- HOLD_CYC, 1, cycles both strobes are low with CONF_D still held after each pulse; ≥1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  host presents cfg_data.
- cfg_ready  output  1  sequencer can accept a word.
- cfg_data  input  CHAIN_LEN  word to shift; bit CHAIN_LEN-1 is sent first.
- busy  output  1  a sequence is in progress.
- done  output  1  one-cycle pulse when the sequence completes.
- rd_data  output  CHAIN_LEN  CONFout samples, first sample in the MSB.
- CONF_D  output  1  drives the chain's CONFin.
- CONF_CLK  output  1  strobe for even pulses (index 0, 2, …).
- CONF_MODE  output  1  strobe for odd pulses (index 1, 3, …).
- CONF_Q  input  1  the chain's CONFout.

Behaviour:
- Reset is asynchronous and active-low. While resetn=0, all outputs are 0: cfg_ready, busy, done, rd_data, CONF_D, CONF_CLK and CONF_MODE. The state is IDLE and the pulse index is 0.
- Reset asserted mid-sequence:
  - Strobes drop to 0 immediately, not at the next edge.
  - The word is discarded and no done pulse is generated.
  - The first edge after release runs in IDLE.
- States: IDLE, SETUP, PULSE, HOLD, DONE.
- IDLE:
  - cfg_ready=1, busy=0.
  - On an edge with cfg_valid=1: latch cfg_data into the shift register, set k=0 and go to SETUP.
  - cfg_valid while not in IDLE is ignored, since cfg_ready=0.
- SETUP:
  - CONF_D = shift-register MSB; both strobes are 0.
  - Stays SETUP_CYC cycles, then goes to PULSE.
- PULSE:
  - CONF_CLK=1 if k is even, otherwise CONF_MODE=1. The two strobes are never 1 in the same cycle.
  - CONF_D is unchanged.
  - Stays PULSE_CYC cycles, then goes to HOLD.
- HOLD:
  - Both strobes are 0; CONF_D is unchanged.
  - In the last HOLD cycle:
    - CONF_Q is shifted into the rd_data LSB;
    - the data shift register shifts left;
    - k increments.
  - If k was CHAIN_LEN-1, go to DONE; otherwise go to SETUP.
- DONE:
  - done=1 for exactly one cycle; rd_data holds all CHAIN_LEN samples; busy=0.
  - Next state is IDLE.
- Strobe and output timing:
  - Strobes and CONF_D are registered, so there are no combinational glitches on them.
  - CONF_D is 0 in IDLE and DONE.
- busy is 1 in SETUP, PULSE and HOLD.
- rd_data holds its value until the next completed sequence. It is cleared to 0 when a new word is accepted.
- Latency:
  - The word is accepted at edge 0.
  - Pulse k occupies the window starting at cycle 1 + k·(SETUP_CYC+PULSE_CYC+HOLD_CYC).
  - done is asserted in cycle CHAIN_LEN·(SETUP_CYC+PULSE_CYC+HOLD_CYC)+1.
  - cfg_ready returns one cycle after done.
- Counter widths: $clog2 of the maximum of SETUP_CYC, PULSE_CYC and HOLD_CYC, plus 1; k is $clog2(CHAIN_LEN) bits. No wrap-around occurs within a sequence.

Test Plan:
- Default parameters, cfg_data=4'b1011 accepted at edge 0:
  - CONF_D is 1, 0, 1, 1 during pulses 0–3;
  - CONF_CLK is high in cycles 2 and 8, CONF_MODE is high in cycles 5 and 11;
  - done=1 in cycle 13 and cfg_ready=1 in cycle 14.
- CONF_Q driven 1, 1, 0, 1 in the last HOLD cycle of pulses 0–3 → rd_data=4'b1101 at done, held until the next accept.
- SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, CHAIN_LEN=2 →
  - each strobe is high for exactly 3 cycles;
  - CONF_D is stable for 7 cycles around each pulse;
  - done is asserted in cycle 15.
- cfg_valid held high throughout, with a new value on cfg_data in cycle 5 → that value is ignored. The next word is accepted only in cycle 14.
- resetn pulled low in the middle of cycle 8 (CONF_CLK high) →
  - CONF_CLK drops within the same cycle;
  - busy=0, no done pulse;
  - after release, cfg_ready=1 and a new word loads correctly.
- Assertion run over random words and random valid gaps, 1000 sequences:
  - CONF_CLK & CONF_MODE is never 1;
  - CONF_D never changes while either strobe is high.
